spi_tx_sequencer: RTL and testbench
===================================

// Module: spi_tx_sequencer
// PURPOSE
// - Upstream feeder for the SPI master transmitter: buffers host bytes in a small FIFO, presents
//   one byte on data_in, pulses strt, tracks the frame via CS, then issues the next byte.
// - Sits between host/register logic and the transmitter's data_in/strt/CS pins.
// PARAMETERS
// - DEPTH       8    FIFO entries; power of two, >= 2
// - STRT_CYC    2    clk cycles strt is held high per frame (>= 1)
// - GAP_CYC     4    idle clk cycles after CS returns high before the next strt
// - TIMEOUT     64   max clk cycles waiting for CS low after strt falls; 0 disables
// PORTS
// - clk        in   1   system clock, all logic on rising edge
// - rst        in   1   asynchronous, active-low reset
// - en         in   1   1 = sequencer may launch frames; 0 = finish current frame, then hold
// - wr_en      in   1   push wr_data into FIFO this cycle
// - wr_data    in   8   byte to transmit
// - CS         in   1   chip select from transmitter (active low during a frame)
// - data_in    out  8   byte presented to transmitter; stable from LOAD until frame end
// - strt       out  1   start request to transmitter
// - full       out  1   FIFO full
// - empty      out  1   FIFO empty
// - count      out  $clog2(DEPTH)+1  FIFO occupancy
// - busy       out  1   1 in any state other than IDLE
// - done       out  1   one-cycle pulse when a frame completes (end of GAP)
// - ovf        out  1   sticky: write attempted while full with no pop that cycle
// - tmo        out  1   sticky: CS never went low within TIMEOUT
// BEHAVIOUR
// - Reset (rst=0, async): FIFO pointers/count=0, data_in=8'h00, strt=0, busy=0, done=0,
//   ovf=0, tmo=0, full=0, empty=1, state=IDLE. Reset mid-frame drops the byte; strt falls at once.
// - FIFO: registered pointers wrap modulo DEPTH; count updates the cycle after push/pop.
//   Push when full: ignored, ovf<=1, unless a pop happens in the same cycle (then both occur).
//   Push when empty and pop same cycle: not possible (pop only when count>0 in IDLE).
// - FSM states: IDLE, LOAD, START, WAIT_LO, WAIT_HI, GAP.
//   IDLE:    if en && !empty && CS==1 -> pop, data_in<=head, go LOAD.
//   LOAD:    1 cycle, data_in settles -> START.
//   START:   strt=1 for exactly STRT_CYC cycles -> WAIT_LO (strt=0).
//   WAIT_LO: CS==0 -> WAIT_HI. With TIMEOUT>0, after TIMEOUT cycles: tmo<=1, byte dropped -> IDLE.
//            CS already low in the strt window also counts (checked every cycle of START and WAIT_LO).
//   WAIT_HI: CS==1 -> GAP. No timeout here (frame length set by transmitter).
//   GAP:     GAP_CYC cycles, then done=1 for one cycle -> IDLE.
// - Latency: pop-to-strt rise = 2 cycles; CS rise to done = GAP_CYC cycles.
// - en deasserted mid-frame: no effect until IDLE; then no new launch.
// - ovf/tmo cleared only by reset.
// - data_in holds last byte after frame; never changes while CS==0.
// STRUCTURE
// - Shared package spi_pkg: state enum, BYTE_W=8 constant, reused by transmitter/receiver benches.
// - Sub-module spi_byte_fifo (DEPTH, BYTE_W): storage, pointers, full/empty/count, ovf.
// - Top holds FSM, STRT_CYC/GAP/TIMEOUT counter (one shared counter, reloaded per state).
// TESTING (bench instantiates this block + transmitter_SPI + receiver_SPI, mode CKP=1 CPH=0)
// - Reset: rst=0 for 20 cycles mid-traffic -> all outputs at reset values, strt=0 within 0 cycles.
// - Single byte: push 8'h55, en=1 -> strt high 2 cycles 2 clk after pop; receiver captures 8'h55;
//   done pulses GAP_CYC=4 cycles after CS rises; empty=1, busy=0.
// - Burst: push 8'hA5,8'h3C,8'hFF -> three frames in order, each separated by >=4 idle cycles,
//   three done pulses, count decrements 3->0.
// - Overflow: push 9 bytes with en=0 -> full=1 after 8, ovf=1, count=8; enable -> 8 frames only.
// - Timeout: tie CS=1 (transmitter disconnected), push 8'h01 -> tmo=1 after 64 cycles, FSM IDLE,
//   byte discarded, count=0.
// - en toggle: drop en during WAIT_HI of frame 1 of 2 -> frame 1 completes, frame 2 waits until en=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width and sequencer state encoding.
// Also reused by the transmitter/receiver benches.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_LO,
    WAIT_HI,
    GAP
  } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte FIFO feeding the SPI sequencer.
// Registered pointers and occupancy, sticky overflow flag.
module spi_byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_tx_sequencer.sv
// Feeds queued bytes to the SPI transmitter one frame at a time.
// Launches strt, follows CS through the frame, then idles a gap.
module spi_tx_sequencer
  import spi_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int STRT_CYC = 2,
  parameter int GAP_CYC  = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  input  logic                   CS,
  output logic [BYTE_W-1:0]      data_in,
  output logic                   strt,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  output logic                   tmo
);

  localparam int M1   = (STRT_CYC > GAP_CYC) ? STRT_CYC : GAP_CYC;
  localparam int MAXC = (M1 > TIMEOUT) ? M1 : TIMEOUT;
  localparam int TW   = $clog2(MAXC + 1) + 1;

  localparam int STRT_LD = STRT_CYC - 1;
  localparam int GAP_LD  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int TMO_LD  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t            state;
  logic [TW-1:0]     cnt;
  logic              cs_seen;
  logic              pop;
  logic [BYTE_W-1:0] head;

  assign pop  = (state == IDLE) && en && !empty && CS;
  assign busy = (state != IDLE);

  spi_byte_fifo #(
    .DEPTH  (DEPTH),
    .BYTE_W (BYTE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf)
  );

  // Frame sequencing with one shared counter reloaded per state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cs_seen <= 1'b0;
      data_in <= '0;
      strt    <= 1'b0;
      done    <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            data_in <= head;
            state   <= LOAD;
          end
        end
        LOAD: begin
          strt    <= 1'b1;
          cnt     <= TW'(STRT_LD);
          cs_seen <= 1'b0;
          state   <= START;
        end
        START: begin
          if (!CS) cs_seen <= 1'b1;
          if (cnt == '0) begin
            strt <= 1'b0;
            if (cs_seen || !CS) begin
              state <= WAIT_HI;
            end else begin
              cnt   <= TW'(TMO_LD);
              state <= WAIT_LO;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_LO: begin
          if (!CS) begin
            state <= WAIT_HI;
          end else if (TIMEOUT > 0 && cnt == '0) begin
            tmo   <= 1'b1;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_HI: begin
          if (CS) begin
            cnt   <= TW'(GAP_LD);
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Bench for spi_tx_sequencer with a behavioural transmitter/receiver.
// Scoreboard of queued bytes checked against bytes seen at CS fall.
module tb_spi_tx_sequencer;

  localparam int DEPTH    = 8;
  localparam int STRT_CYC = 2;
  localparam int GAP_CYC  = 4;
  localparam int TIMEOUT  = 64;

  logic       clk;
  logic       rst;
  logic       en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       CS;
  logic [7:0] data_in;
  logic       strt;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       tmo;

  spi_tx_sequencer #(
    .DEPTH    (DEPTH),
    .STRT_CYC (STRT_CYC),
    .GAP_CYC  (GAP_CYC),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .CS      (CS),
    .data_in (data_in),
    .strt    (strt),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .tmo     (tmo)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic disc = 1'b0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    wr_en   = 1'b1;
    wr_data = b;
    if (keep && q.size() < DEPTH) q.push_back(b);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int tgt;
    int b;
    tgt = done_cnt + n;
    b = 0;
    while (done_cnt < tgt && b < 100 * n) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (done_cnt < tgt) chk("wait_done", done_cnt, tgt);
  endtask

  // Transmitter/receiver model: CS low 3 cycles after strt, 12-cycle frame.
  initial begin
    CS = 1'b1;
    forever begin
      @(negedge clk);
      if (strt && rst) begin
        repeat (3) @(posedge clk);
        #1;
        if (!disc && rst) begin
          rx_last = data_in;
          CS = 1'b0;
          if (q.size() == 0) chk("sb_extra", int'(data_in), -1);
          else chk("rx_byte", int'(data_in), int'(q.pop_front()));
          repeat (12) @(posedge clk);
          #1;
          CS = 1'b1;
        end
      end
    end
  end

  // Timing monitor.
  int   slen = 0;
  int   last_idle = 0;
  int   sfall = 0;
  int   cs_cyc = 0;
  logic p_strt = 1'b0;
  logic p_cs = 1'b1;
  logic p_tmo = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      slen   = 0;
      p_strt = 1'b0;
      p_cs   = 1'b1;
      p_tmo  = 1'b0;
    end else begin
      if (!busy) last_idle = cyc;
      if (strt && !p_strt) chk("pop2strt", cyc - last_idle, 2);
      if (strt) slen++;
      else if (p_strt) begin
        chk("strt_len", slen, STRT_CYC);
        slen  = 0;
        sfall = cyc;
      end
      if (CS && !p_cs) cs_cyc = cyc;
      if (done) begin
        done_cnt++;
        chk("cs2done", cyc - (cs_cyc + 1), GAP_CYC);
        chk("cnt_done", int'(count), q.size());
        chk("busy_done", int'(busy), 0);
      end
      if (tmo && !p_tmo) chk("tmo_lat", cyc - sfall, TIMEOUT);
      if (!CS) chk("hold", int'(data_in), int'(rx_last));
      p_strt = strt;
      p_cs   = CS;
      p_tmo  = tmo;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_strt"}, int'(strt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_tmo"}, int'(tmo), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_data"}, int'(data_in), 0);
  endtask

  initial begin
    int b;
    rst = 1'b0;
    en = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // single byte
    en = 1'b1;
    push(8'h55, 1'b1);
    wait_done(1);
    chk("single_empty", int'(empty), 1);
    chk("single_busy", int'(busy), 0);

    // burst of three
    en = 1'b0;
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    push(8'hFF, 1'b1);
    chk("burst_cnt", int'(count), 3);
    en = 1'b1;
    wait_done(3);
    chk("burst_cnt0", int'(count), 0);

    // overflow: nine pushes into eight entries
    en = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i), 1'b1);
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_cnt", int'(count), DEPTH);
    en = 1'b1;
    wait_done(8);
    repeat (40) @(posedge clk);
    #1;
    chk("ovf_idle", int'(busy), 0);
    chk("ovf_drain", q.size(), 0);
    chk("ovf_sticky", int'(ovf), 1);

    // timeout with transmitter disconnected
    disc = 1'b1;
    push(8'h01, 1'b0);
    b = 0;
    while (!tmo && b < 300) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("tmo_flag", int'(tmo), 1);
    @(posedge clk);
    #1;
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_cnt", int'(count), 0);
    disc = 1'b0;

    // en dropped during WAIT_HI of frame 1 of 2
    push(8'h81, 1'b1);
    push(8'h7E, 1'b1);
    b = 0;
    while (CS && b < 100) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("en_cs_low", int'(CS), 0);
    en = 1'b0;
    wait_done(1);
    repeat (30) @(posedge clk);
    #1;
    chk("en_hold_busy", int'(busy), 0);
    chk("en_hold_cnt", int'(count), 1);
    en = 1'b1;
    wait_done(1);
    chk("en_cnt0", int'(count), 0);

    // reset mid-traffic
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    b = 0;
    while (!strt && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("mid_strt", int'(strt), 1);
    rst = 1'b0;
    #1;
    chk("mid_strt_drop", int'(strt), 0);
    q.delete();
    repeat (20) @(posedge clk);
    #1;
    chk_reset("rst1");
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
